// File: rtl/accum_16b.sv
// accum_16b: frame accumulator for 16-bit unsigned terms.
// Terms are summed modulo 2^16 while a sticky carry records any wrap.
// A frame closes on in_last or once N_TERMS terms have been taken.
// The result is then held until downstream takes it.
module accum_16b #(
    parameter int unsigned N_TERMS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_carry,
    output logic [7:0]  out_count
);

    typedef enum logic {
        ST_ACC,
        ST_OUT
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] acc;
    logic        carry;
    logic [7:0]  count;

    logic        accept;
    logic        close;
    logic        release_result;
    logic [16:0] sum_wide;
    logic [8:0]  count_inc;

    // Both handshakes are suppressed while reset is held, so nothing is
    // accepted or presented during reset.
    assign in_ready       = (state == ST_ACC) && !rst;
    assign out_valid      = (state == ST_OUT) && !rst;

    assign accept         = in_valid && in_ready;
    assign release_result = out_valid && out_ready;

    // The widened add exposes the carry-out of the modulo-2^16 sum.
    assign sum_wide       = {1'b0, acc} + {1'b0, in_data};

    // The term count is widened so that N_TERMS = 255 compares cleanly.
    assign count_inc      = {1'b0, count} + 9'd1;
    assign close          = accept && (in_last || (count_inc == 9'(N_TERMS)));

    assign out_sum        = acc;
    assign out_carry      = carry;
    assign out_count      = count;

    // Next-state selection: close a frame into OUT, release it back to ACC.
    always_comb begin
        state_next = state;
        case (state)
            ST_ACC:  if (close)          state_next = ST_OUT;
            ST_OUT:  if (release_result) state_next = ST_ACC;
            default: state_next = ST_ACC;
        endcase
    end

    // State register; reset always returns to accepting terms.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ACC;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: accumulate accepted terms; clear on reset or when the result is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= 16'd0;
            carry <= 1'b0;
            count <= 8'd0;
        end else if (release_result) begin
            acc   <= 16'd0;
            carry <= 1'b0;
            count <= 8'd0;
        end else if (accept) begin
            acc   <= sum_wide[15:0];
            carry <= carry | sum_wide[16];
            count <= count_inc[7:0];
        end
    end

endmodule

// File: tb/tb_accum_16b.sv
// tb_accum_16b: directed and random stimulus for accum_16b.
// A frame-level model (integer total of the terms, term count, holding flag)
// predicts every output each cycle. Literal checks pin the known frames.
// A second instance with N_TERMS = 1 covers the single-term frame case.
module tb_accum_16b;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_sum;
    logic        out_carry;
    logic [7:0]  out_count;

    logic        in_ready1;
    logic        out_valid1;
    logic [15:0] out_sum1;
    logic        out_carry1;
    logic [7:0]  out_count1;

    int n_vectors    = 0;
    int n_miscompares = 0;

    // Model for N_TERMS = 4: the exact integer total decides both the sum and the carry.
    bit m_hold  = 0;
    int m_total = 0;
    int m_count = 0;

    // Model for N_TERMS = 1.
    bit          m1_hold = 0;
    logic [15:0] m1_sum  = 16'd0;

    accum_16b #(.N_TERMS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_count (out_count)
    );

    accum_16b #(.N_TERMS(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_sum   (out_sum1),
        .out_carry (out_carry1),
        .out_count (out_count1)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h",
                     name, $time, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge consume them, and return 1 time unit later.
    task automatic applyStimulus(input logic v, input logic [15:0] d,
                                 input logic l, input logic ordy);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    // Frame-level reference: apply the rules to the inputs seen at each edge.
    always @(posedge clk) begin
        if (rst) begin
            m_hold  = 0;
            m_total = 0;
            m_count = 0;
            m1_hold = 0;
            m1_sum  = 16'd0;
        end else begin
            if (m_hold) begin
                if (out_ready) begin
                    m_hold  = 0;
                    m_total = 0;
                    m_count = 0;
                end
            end else if (in_valid) begin
                m_total = m_total + int'(in_data);
                m_count = m_count + 1;
                if (in_last || m_count == 4) m_hold = 1;
            end
            if (m1_hold) begin
                if (out_ready) m1_hold = 0;
            end else if (in_valid) begin
                m1_sum  = in_data;
                m1_hold = 1;
            end
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        checkOutput("in_ready",  {31'd0, in_ready},  {31'd0, !rst && !m_hold});
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, !rst && m_hold});
        if (!rst) begin
            checkOutput("out_sum",   {16'd0, out_sum},   m_total % 65536);
            checkOutput("out_carry", {31'd0, out_carry}, {31'd0, m_total > 65535});
            checkOutput("out_count", {24'd0, out_count}, m_count);
        end
        checkOutput("in_ready1",  {31'd0, in_ready1},  {31'd0, !rst && !m1_hold});
        checkOutput("out_valid1", {31'd0, out_valid1}, {31'd0, !rst && m1_hold});
        if (!rst && m1_hold) begin
            checkOutput("out_sum1",   {16'd0, out_sum1},   {16'd0, m1_sum});
            checkOutput("out_carry1", {31'd0, out_carry1}, 32'd0);
            checkOutput("out_count1", {24'd0, out_count1}, 32'd1);
        end
    end

    // Directed frames with literal expectations, then a random stream.
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("post_rst_sum", {16'd0, out_sum}, 32'd0);
        checkOutput("post_rst_count", {24'd0, out_count}, 32'd0);

        // Four terms close the frame by count.
        applyStimulus(1, 16'h0001, 0, 1);
        applyStimulus(1, 16'h0002, 0, 1);
        applyStimulus(1, 16'h0003, 0, 1);
        applyStimulus(1, 16'h0004, 0, 1);
        checkOutput("f1_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("f1_sum", {16'd0, out_sum}, 32'h000A);
        checkOutput("f1_carry", {31'd0, out_carry}, 32'd0);
        checkOutput("f1_count", {24'd0, out_count}, 32'd4);
        applyStimulus(0, 16'h0000, 0, 1);
        checkOutput("f1_ready_after", {31'd0, in_ready}, 32'd1);

        // Early close with a wrap.
        applyStimulus(1, 16'hFFFF, 0, 1);
        applyStimulus(1, 16'h0002, 1, 1);
        checkOutput("f2_sum", {16'd0, out_sum}, 32'h0001);
        checkOutput("f2_carry", {31'd0, out_carry}, 32'd1);
        checkOutput("f2_count", {24'd0, out_count}, 32'd2);
        applyStimulus(0, 16'h0000, 0, 1);

        // Carry stays set for the rest of the frame.
        applyStimulus(1, 16'h8000, 0, 1);
        applyStimulus(1, 16'h8000, 0, 1);
        checkOutput("f3_carry_mid", {31'd0, out_carry}, 32'd1);
        applyStimulus(1, 16'h0005, 0, 1);
        applyStimulus(1, 16'h0000, 0, 1);
        checkOutput("f3_sum", {16'd0, out_sum}, 32'h0005);
        checkOutput("f3_carry", {31'd0, out_carry}, 32'd1);
        checkOutput("f3_count", {24'd0, out_count}, 32'd4);
        applyStimulus(0, 16'h0000, 0, 1);

        // Backpressure: the result holds while fresh terms wait.
        for (int i = 0; i < 4; i++) applyStimulus(1, 16'h0010, 0, 0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_sum", {16'd0, out_sum}, 32'h0040);
            checkOutput("bp_ready", {31'd0, in_ready}, 32'd0);
            applyStimulus(1, 16'h1234, 0, 0);
        end
        applyStimulus(1, 16'h1234, 0, 1);
        checkOutput("bp_released_count", {24'd0, out_count}, 32'd0);
        applyStimulus(1, 16'h1234, 0, 1);
        checkOutput("bp_first_sum", {16'd0, out_sum}, 32'h1234);
        checkOutput("bp_first_count", {24'd0, out_count}, 32'd1);
        applyStimulus(1, 16'h0000, 1, 1);
        applyStimulus(0, 16'h0000, 0, 1);

        // Reset mid-frame discards the partial sum; beats during reset are ignored.
        applyStimulus(1, 16'h0100, 0, 1);
        applyStimulus(1, 16'h0100, 0, 1);
        rst = 1'b1;
        applyStimulus(1, 16'h0100, 0, 1);
        checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_count", {24'd0, out_count}, 32'd0);
        applyStimulus(1, 16'h0003, 1, 1);
        checkOutput("mid_rst_sum", {16'd0, out_sum}, 32'h0003);
        checkOutput("mid_rst_count2", {24'd0, out_count}, 32'd1);
        checkOutput("mid_rst_valid2", {31'd0, out_valid}, 32'd1);
        applyStimulus(0, 16'h0000, 0, 1);

        // Reset while holding a result drops it.
        for (int i = 0; i < 4; i++) applyStimulus(1, 16'h0007, 0, 0);
        rst = 1'b1;
        applyStimulus(0, 16'h0000, 0, 0);
        rst = 1'b0;
        applyStimulus(0, 16'h0000, 0, 1);
        checkOutput("hold_rst_valid", {31'd0, out_valid}, 32'd0);

        // Random stream with varied valid, last and ready.
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] d;
            d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hF000, 16'hFFFF))
                                           : 16'($urandom);
            applyStimulus(1'($urandom_range(0, 3) != 0), d,
                          1'($urandom_range(0, 4) == 0),
                          1'($urandom_range(0, 3) != 0));
        end

        applyStimulus(0, 16'h0000, 0, 1);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/accum_16b.md
ACCUM_16B -- requirements
Module: accum_16b

Interface
REQ-001 Parameter N_TERMS, default 4, sets the maximum terms per frame; legal range 1..255.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 Port in_valid, input, 1 bit: upstream presents a term on in_data.
REQ-005 Port in_ready, output, 1 bit: block accepts a term this cycle.
REQ-006 Port in_data, input, 16 bits: unsigned term to accumulate.
REQ-007 Port in_last, input, 1 bit: qualified by in_valid; the accompanying term closes the frame early.
REQ-008 Port out_valid, output, 1 bit: frame result is presented.
REQ-009 Port out_ready, input, 1 bit: downstream accepts the result.
REQ-010 Port out_sum, output, 16 bits: frame sum modulo 2^16.
REQ-011 Port out_carry, output, 1 bit: sticky OR of every carry-out generated in the frame.
REQ-012 Port out_count, output, 8 bits: number of terms accepted in the frame.

Function
REQ-013 Two states: ACC (accepting terms) and OUT (holding the result); the state encoding is internal.
REQ-014 Beat acceptance: accepted = in_valid & in_ready; no term is consumed when in_ready is 0.
REQ-015 In ACC, in_ready = 1 and out_valid = 0.
REQ-016 In OUT, in_ready = 0 and out_valid = 1.
REQ-017 Accepted beat in ACC updates, on the next edge:
  - acc <= (acc + in_data) mod 2^16
  - carry <= carry | carry-out of that addition
  - count <= count + 1
REQ-018 Frame close: an accepted beat with in_last = 1, or with count + 1 == N_TERMS, moves ACC -> OUT on the same edge that performs the update in REQ-017.
REQ-019 Latency: out_valid rises exactly one cycle after the closing beat is accepted, and out_sum/out_carry/out_count already include that beat.
REQ-020 In OUT, out_sum, out_carry and out_count hold stable until the handshake completes, whatever in_valid/in_data do.
REQ-021 Result handshake:
  - out_valid & out_ready at an edge: acc, carry and count clear to 0 and state -> ACC
  - in_ready = 1 from the next cycle
REQ-022 out_valid may remain high indefinitely while out_ready = 0; the result is never dropped or altered.
REQ-023 Wrap-around: a sum exceeding 0xFFFF wraps modulo 2^16 and sets carry; carry stays 1 for the rest of the frame.
REQ-024 N_TERMS = 1: every accepted beat closes a frame, giving out_count = 1.
REQ-025 in_last on the N_TERMS-th beat closes the frame once, with no double close and no empty frame.
REQ-026 in_last and in_data are ignored when in_valid = 0 or in_ready = 0.
REQ-027 Throughput ceiling: one frame per (terms + 1) cycles when out_ready is held 1.
REQ-028 In ACC, out_sum, out_carry and out_count reflect the running acc, carry and count; they are don't-care to downstream because out_valid = 0.

Reset
REQ-029 rst = 1 at an edge forces, on that edge: state ACC, acc = 0, carry = 0, count = 0.
REQ-030 While rst = 1: in_ready = 0 and out_valid = 0.
REQ-031 First cycle after rst deasserts: in_ready = 1, out_valid = 0, out_sum = 0, out_carry = 0, out_count = 0.
REQ-032 Reset takes priority over every handshake.
REQ-033 Reset mid-frame or in OUT discards the partial or held result; no out_valid pulse follows reset.
REQ-034 Beats presented while rst = 1 are not accepted.

Verification
REQ-035 N_TERMS=4, terms 0x0001, 0x0002, 0x0003, 0x0004 back-to-back, out_ready=1 -> out_valid one cycle after the 4th beat; out_sum=0x000A, out_carry=0, out_count=4; in_ready=1 on the following cycle.
REQ-036 Terms 0xFFFF, 0x0002, in_last on 2nd -> out_sum=0x0001, out_carry=1, out_count=2.
REQ-037 Terms 0x8000, 0x8000, 0x0005, 0x0000 -> out_sum=0x0005, out_carry=1 (sticky after 2nd beat), out_count=4.
REQ-038 Backpressure: frame 0x0010 x4 with out_ready=0 for 5 cycles while in_valid stays 1 with in_data=0x1234 -> out_sum holds 0x0040, in_ready=0 throughout, and the 0x1234 beats are not accepted until the cycle after out_ready=1.
REQ-039 Reset mid-frame: 2 beats 0x0100 accepted, rst=1 for 1 cycle, then 0x0003 with in_last -> out_sum=0x0003, out_count=1, and no out_valid before it.
REQ-040 Random stream of 1000 beats with random in_last, in_valid and out_ready, checked against a reference model of sum mod 2^16, sticky carry and count -> zero mismatches.
